// File: rtl/plot_writer.sv
// plot_writer: buffers plot requests, clips off-screen points and writes pixels to the framebuffer.
// A clear request drains queued plots first, then fills every address with the latched colour.
module plot_writer #(
  parameter int COLOUR_W = 1,
  parameter int DEPTH    = 4,
  parameter int H_RES    = 320,
  parameter int V_RES    = 240
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot_valid,
  output logic                plot_ready,
  input  logic [8:0]          plot_x,
  input  logic [7:0]          plot_y,
  input  logic [COLOUR_W-1:0] plot_colour,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  input  logic                mem_stall,
  output logic [16:0]         mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_wren,
  output logic [7:0]          clip_count,
  output logic                clear_done,
  output logic                busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 17 + COLOUR_W;
  localparam logic [16:0] LAST = 17'(H_RES * V_RES - 1);

  typedef enum logic {RUN, CLEAR} state_t;
  state_t r_state, w_state_nxt;

  logic [EW-1:0]       r_fifo [DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_count;
  logic                r_pending;
  logic [COLOUR_W-1:0] r_clr_colour;
  logic [16:0]         r_clr_addr;
  logic [16:0]         r_mem_addr;
  logic [COLOUR_W-1:0] r_mem_data;
  logic                r_mem_wren;
  logic                r_clear_done;
  logic [7:0]          r_clip;

  logic                w_push, w_pop, w_on, w_wr;
  logic                w_clr_wr, w_clr_last, w_clr_accept, w_clr_enter;
  logic [8:0]          w_hx;
  logic [7:0]          w_hy;
  logic [COLOUR_W-1:0] w_hc;
  logic [16:0]         w_hy17, w_addr;

  assign {w_hx, w_hy, w_hc} = r_fifo[r_rp];
  assign w_hy17 = {9'd0, w_hy};
  // y*320 + x as shifts so no multiplier is needed
  assign w_addr = (w_hy17 << 8) + (w_hy17 << 6) + {8'd0, w_hx};
  assign w_on   = (32'(w_hx) < 32'(H_RES)) && (32'(w_hy) < 32'(V_RES));

  assign plot_ready   = resetn && (r_count != CW'(DEPTH)) && (r_state == RUN) && !r_pending;
  assign w_push       = plot_valid && plot_ready;
  assign w_pop        = (r_state == RUN) && !mem_stall && (r_count != '0);
  assign w_wr         = w_pop && w_on;
  assign w_clr_wr     = (r_state == CLEAR) && !mem_stall;
  assign w_clr_last   = r_clr_addr == LAST;
  assign w_clr_accept = clear_req && (r_state == RUN) && !r_pending;
  assign w_clr_enter  = (r_state == RUN) && r_pending && (r_count == '0) && !mem_stall;

  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign mem_wren   = r_mem_wren;
  assign clip_count = r_clip;
  assign clear_done = r_clear_done;
  assign busy       = (r_count != '0) || r_pending || (r_state == CLEAR) || r_mem_wren;

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_enter) w_state_nxt = CLEAR;
    else if (w_clr_wr && w_clr_last) w_state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= RUN;
    else r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= {plot_x, plot_y, plot_colour};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_count      <= '0;
      r_pending    <= 1'b0;
      r_clr_colour <= '0;
      r_clr_addr   <= '0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_wren   <= 1'b0;
      r_clear_done <= 1'b0;
      r_clip       <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_clr_accept) begin
        r_pending    <= 1'b1;
        r_clr_colour <= clear_colour;
      end else if (w_clr_enter) r_pending <= 1'b0;
      if (w_clr_wr) r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
      // a stalled memory keeps the current write presented unchanged
      if (!mem_stall) begin
        r_mem_wren <= w_clr_wr || w_wr;
        if (w_clr_wr) begin
          r_mem_addr <= r_clr_addr;
          r_mem_data <= r_clr_colour;
        end else if (w_wr) begin
          r_mem_addr <= w_addr;
          r_mem_data <= w_hc;
        end
      end
      if (w_pop && !w_on && r_clip != 8'hFF) r_clip <= r_clip + 1'b1;
      r_clear_done <= w_clr_wr && w_clr_last;
    end
  end
endmodule

// File: tb/tb_plot_writer.sv
// tb_plot_writer: directed tests for plot_writer with hand-computed expected values.
module tb_plot_writer;
  logic       clk = 0, resetn = 0, plot_valid = 0, clear_req = 0, mem_stall = 0;
  logic [8:0] plot_x = 0;
  logic [7:0] plot_y = 0;
  logic       plot_colour = 0, clear_colour = 0;
  logic       plot_ready, mem_wren, clear_done, busy;
  logic       mem_data;
  logic [16:0] mem_addr;
  logic [7:0] clip_count;
  int         n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  plot_writer dut (
    .clk(clk), .resetn(resetn), .plot_valid(plot_valid), .plot_ready(plot_ready),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .clear_req(clear_req), .clear_colour(clear_colour), .mem_stall(mem_stall),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .clip_count(clip_count), .clear_done(clear_done), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad, pulses, acc, xn;
    logic rdy, a;
    int cx [4] = '{0, 319, 320, 0};
    int cy [4] = '{0, 239, 0, 240};
    // reset state
    tick(3);
    check("rst_wren", 32'(mem_wren), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(plot_ready), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_clip", 32'(clip_count), 0);
    check("rst_done", 32'(clear_done), 0);
    resetn = 1;
    tick();
    check("run_ready", 32'(plot_ready), 1);
    // single request and latency
    plot_x = 10; plot_y = 5; plot_colour = 1; plot_valid = 1;
    tick();
    plot_valid = 0;
    check("t1_wren_k", 32'(mem_wren), 0);
    check("t1_busy_k", 32'(busy), 1);
    tick();
    check("t1_wren", 32'(mem_wren), 1);
    check("t1_addr", 32'(mem_addr), 1610);
    check("t1_data", 32'(mem_data), 1);
    tick();
    check("t1_wren_off", 32'(mem_wren), 0);
    check("t1_busy_off", 32'(busy), 0);
    // corners back-to-back
    for (int i = 0; i < 4; i++) begin
      plot_x = 9'(cx[i]); plot_y = 8'(cy[i]); plot_colour = 1; plot_valid = 1;
      check("t2_ready", 32'(plot_ready), 1);
      tick();
      if (i == 0) check("t2_w0", 32'(mem_wren), 0);
      if (i == 1) begin
        check("t2_w1", 32'(mem_wren), 1);
        check("t2_a1", 32'(mem_addr), 0);
      end
      if (i == 2) begin
        check("t2_w2", 32'(mem_wren), 1);
        check("t2_a2", 32'(mem_addr), 76799);
      end
      if (i == 3) begin
        check("t2_w3", 32'(mem_wren), 0);
        check("t2_clip1", 32'(clip_count), 1);
      end
    end
    plot_valid = 0;
    tick();
    check("t2_w4", 32'(mem_wren), 0);
    check("t2_clip2", 32'(clip_count), 2);
    tick();
    check("t2_busy", 32'(busy), 0);
    // stall with full FIFO
    mem_stall = 1;
    for (int i = 0; i < 4; i++) begin
      plot_x = 9'(i); plot_y = 1; plot_colour = 1; plot_valid = 1;
      check("t3_ready_acc", 32'(plot_ready), 1);
      tick();
    end
    plot_x = 4;
    for (int i = 0; i < 2; i++) begin
      check("t3_ready_full", 32'(plot_ready), 0);
      check("t3_wren_stall", 32'(mem_wren), 0);
      tick();
    end
    check("t3_busy", 32'(busy), 1);
    mem_stall = 0;
    xn = 4;
    for (int j = 0; j < 6; j++) begin
      a = plot_valid & plot_ready;
      tick();
      check("t3_wren", 32'(mem_wren), 1);
      check("t3_addr", 32'(mem_addr), 32'(320 + j));
      if (a) begin
        xn++;
        plot_x = 9'(xn);
        if (xn == 6) plot_valid = 0;
      end
    end
    mem_stall = 1;
    tick();
    check("t3_hold_wren", 32'(mem_wren), 1);
    check("t3_hold_addr", 32'(mem_addr), 325);
    mem_stall = 0;
    tick();
    check("t3_wren_off", 32'(mem_wren), 0);
    check("t3_busy_off", 32'(busy), 0);
    // queued plots then full-screen clear
    mem_stall = 1;
    for (int i = 1; i <= 2; i++) begin
      plot_x = 9'(i); plot_y = 0; plot_colour = 1; plot_valid = 1;
      tick();
    end
    plot_valid = 0;
    clear_req = 1; clear_colour = 0;
    tick();
    clear_req = 0;
    check("t4_pend_ready", 32'(plot_ready), 0);
    check("t4_pend_busy", 32'(busy), 1);
    mem_stall = 0;
    tick();
    check("t4_p1_wren", 32'(mem_wren), 1);
    check("t4_p1_addr", 32'(mem_addr), 1);
    tick();
    check("t4_p2_addr", 32'(mem_addr), 2);
    tick();
    check("t4_enter_wren", 32'(mem_wren), 0);
    check("t4_enter_ready", 32'(plot_ready), 0);
    bad = 0; pulses = 0;
    for (int n = 0; n < 76800; n++) begin
      tick();
      if (!(mem_wren === 1'b1 && 32'(mem_addr) == n && mem_data === 1'b0)) bad++;
      if (n < 76799 && plot_ready !== 1'b0) bad++;
      if (clear_done) pulses++;
      if (n == 76799) check("t4_done", 32'(clear_done), 1);
    end
    check("t4_seq_errs", 32'(bad), 0);
    check("t4_pulses", 32'(pulses), 1);
    tick();
    check("t4_done_off", 32'(clear_done), 0);
    check("t4_wren_off", 32'(mem_wren), 0);
    check("t4_busy_off", 32'(busy), 0);
    check("t4_ready_on", 32'(plot_ready), 1);
    // reset in the middle of a clear
    clear_req = 1; clear_colour = 1;
    tick();
    clear_req = 0;
    tick(1001);
    check("t5_mid_wren", 32'(mem_wren), 1);
    check("t5_mid_addr", 32'(mem_addr), 999);
    check("t5_mid_data", 32'(mem_data), 1);
    resetn = 0;
    tick();
    check("t5_rst_wren", 32'(mem_wren), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_addr", 32'(mem_addr), 0);
    check("t5_rst_ready", 32'(plot_ready), 0);
    check("t5_rst_clip", 32'(clip_count), 0);
    resetn = 1;
    tick();
    check("t5_ready", 32'(plot_ready), 1);
    plot_x = 3; plot_y = 2; plot_colour = 1; plot_valid = 1;
    tick();
    plot_valid = 0;
    tick();
    check("t5_wren", 32'(mem_wren), 1);
    check("t5_addr", 32'(mem_addr), 643);
    tick();
    check("t5_busy_off", 32'(busy), 0);
    // clip counter saturation
    plot_x = 400; plot_y = 0; plot_valid = 1;
    acc = 0; bad = 0;
    for (int k = 0; k < 1000 && acc < 300; k++) begin
      rdy = plot_ready;
      tick();
      if (rdy) acc++;
      if (acc == 300) plot_valid = 0;
      if (mem_wren) bad++;
    end
    plot_valid = 0;
    tick(3);
    check("t6_accepted", 32'(acc), 300);
    check("t6_no_writes", 32'(bad), 0);
    check("t6_clip_sat", 32'(clip_count), 255);
    check("t6_busy_off", 32'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/plot_writer.md
Name: plot_writer

Overview:
- Receiving end of the line-drawing plot stream.
- Accepts (x, y, colour) plot requests through a valid/ready handshake and buffers them in a small FIFO.
- Converts each request to a linear framebuffer address (y*320 + x), clips off-screen points, and drives the framebuffer write port.
- Also performs a full-screen clear on request; sits between the line-drawing FSM and the VGA framebuffer memory.

Parameters:
- COLOUR_W, 1, colour bits per pixel
- DEPTH, 4, request FIFO depth (power of two, >= 2)
- H_RES, 320, visible width in pixels
- V_RES, 240, visible height in pixels

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- plot_valid  in  1  plot request present
- plot_ready  out  1  block can accept a request this cycle
- plot_x  in  9  pixel column
- plot_y  in  8  pixel row
- plot_colour  in  COLOUR_W  pixel colour
- clear_req  in  1  one-cycle pulse: clear whole screen
- clear_colour  in  COLOUR_W  fill colour, sampled with clear_req
- mem_stall  in  1  framebuffer cannot take a write this cycle
- mem_addr  out  17  framebuffer word address
- mem_data  out  COLOUR_W  framebuffer write data
- mem_wren  out  1  write enable
- clip_count  out  8  saturating count of discarded off-screen requests
- clear_done  out  1  one-cycle pulse when a clear completes
- busy  out  1  any work outstanding

Behaviour:
- One clock, `clk`; reset is synchronous and active-low (`resetn`).
- Reset (resetn=0 at a rising edge), applied from any state including mid-clear:
  - FIFO emptied, state RUN, clear_pending=0.
  - mem_addr=0, mem_data=0, mem_wren=0, clip_count=0, clear_done=0, busy=0.
  - plot_ready=0 while resetn=0.
- plot_ready = resetn & (fifo_count < DEPTH) & (state==RUN) & !clear_pending.
- Ready is combinational from registered state only, with no same-cycle pop bypass: when full, ready=0 even if a pop occurs.
- Push: plot_valid & plot_ready at an edge stores {x, y, colour}. While ready=0, valid requests are held by the source; the block drops nothing.
- Pop and write (state RUN, mem_stall=0, FIFO non-empty) at an edge:
  - Head entry is popped.
  - If x < H_RES and y < V_RES: mem_addr = y*320 + x (computed as (y<<8) + (y<<6) + x, 17 bits), mem_data = colour, mem_wren = 1.
  - Otherwise: mem_wren = 0 and clip_count increments, saturating at 255.
- If no pop occurs at an edge and mem_stall=0, mem_wren becomes 0.
- Latency: request accepted at edge k gives mem_wren=1 during the cycle after edge k+1, provided the FIFO was empty and there was no stall. Throughput is 1 pixel per cycle.
- mem_stall=1: no pop, no clear advance. mem_addr, mem_data and mem_wren hold their values. Pushes continue while space remains.
- Simultaneous push and pop at the same edge: both occur and fifo_count is unchanged.
- clear_req=1 in RUN with clear_pending=0: latch clear_colour and set clear_pending. FIFO contents are drained first so ordering is preserved.
- In RUN with clear_pending=1, FIFO empty and mem_stall=0: enter CLEAR and clear clear_pending.
- CLEAR state:
  - Each non-stalled edge issues mem_wren=1, mem_data = latched colour, mem_addr = 0, 1, …, 76799 in order.
  - The edge that issues address 76799 returns the state to RUN.
  - clear_done=1 for the one cycle following that edge.
- clear_req is ignored while clear_pending=1 or in CLEAR.
- busy = (fifo_count != 0) | clear_pending | (state==CLEAR) | mem_wren.
- FIFO pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH and never over- or underflows.

Test Plan:
- Reset then single request (x=10, y=5, colour=1): accepted at edge k → mem_wren=1, mem_addr=1610, mem_data=1 for exactly one cycle after edge k+1; busy returns to 0.
- Corner requests (0,0), (319,239), (320,0), (0,240) back-to-back → writes at addresses 0 and 76799 only; clip_count=2; no mem_wren for the clipped points.
- Hold mem_stall=1 and offer 6 requests → 4 accepted; plot_ready=0 with 2 held; release stall → 4 writes in order on consecutive cycles, then the remaining 2.
- Two queued plots, then clear_req with clear_colour=0 → both plots written first; then 76800 consecutive writes addr 0..76799 with data 0; clear_done pulses once; plot_ready=0 throughout.
- resetn=0 mid-clear at address ~1000 → next cycle mem_wren=0, busy=0, FIFO empty; a new request after reset is written normally.
- Overflow saturation: 300 off-screen requests → clip_count stops at 255 and no writes occur.
